data_mem_resp: RTL
==================

// Module: data_mem_resp
// PURPOSE
//  Data-memory responder: the target end of the MEM-stage memory interface (ce/wrn/addr/wrdata -> redata).
//  Word-organised RAM with a one-entry posted-write buffer and store-to-load forwarding.
//  Read data is combinational so the MEM stage can return load data in the same cycle.
//  Also keeps sticky error flags and access counters for debug and bench checks.
// PARAMETERS
//  DEPTH_LOG2   10   log2 of RAM depth in 32-bit words (1024 words = 4 KiB)
//  CNT_W        16   width of rd_cnt / wr_cnt access counters
// PORTS
//  clk            in   1     pipeline clock, rising edge
//  rst            in   1     reset, asynchronous, active-low
//  mem_ce         in   1     access enable (`ENABLE = active)
//  mem_wrn        in   1     `ENABLE = store, `DISABLE = load; ignored when mem_ce inactive
//  mem_wraddr     in   32    byte address, used for both loads and stores
//  mem_wrdata     in   32    store data
//  mem_redata     out  32    load data, combinational from address and current state
//  wb_pending     out  1     posted write held in buffer, not yet in RAM
//  err_misalign   out  1     sticky: an access had mem_wraddr[1:0] != 0
//  err_range      out  1     sticky: an access had mem_wraddr[31:DEPTH_LOG2+2] != 0
//  rd_cnt         out  CNT_W count of accepted loads, wraps modulo 2^CNT_W
//  wr_cnt         out  CNT_W count of accepted stores, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Word index idx = mem_wraddr[DEPTH_LOG2+1:2]. An access is valid iff mem_ce active, addr[1:0]==0 and range bits are 0.
//  - Reset (rst low, async): wb_pending=0, buffer addr/data=0, err_*=0, rd_cnt=wr_cnt=0.
//    RAM contents are not cleared. A buffered write pending at reset is discarded, never committed.
//  - mem_redata: mem_ce inactive or invalid access -> `ZeroWord.
//    Valid load with wb_pending and buf_idx==idx -> buf_data (forwarding); otherwise RAM[idx].
//    Load latency 0 cycles; a store in cycle N is visible to a load in cycle N+1 through the buffer.
//    A load in the same cycle as the store returns the pre-store value.
//  - Valid store at posedge:
//    if wb_pending, commit buf -> RAM[buf_idx] and capture new idx/data into buf; wb_pending stays 1.
//    If not wb_pending, capture into buf and set wb_pending=1.
//  - No valid store at posedge and wb_pending: commit buf -> RAM, wb_pending=0 (drain, 1 cycle).
//  - Back-to-back stores to the same idx: the older value is committed, then overwritten at the next commit.
//    The last store wins. Forwarding always returns the newest value.
//  - Invalid store: RAM and buffer unchanged; the drain rule still applies; the error flag is set at posedge.
//  - Misaligned and out-of-range on the same access set both flags. Flags clear only on reset.
//  - Counters: rd_cnt +1 per valid load cycle, wr_cnt +1 per valid store cycle. Invalid accesses are not counted.
//  - Loads never change RAM or buffer state other than through the drain rule.
// STRUCTURE
//  - defines.v: `RegDataBus, `ZeroWord, `ENABLE/`DISABLE, new `DMemDepthLog2 default 10.
//  - Sub-module dmem_wbuf: the one-entry posted-write buffer (valid/idx/data regs).
//    It provides the commit strobe, commit idx and data, and the forward hit and data.
//  - The top level holds the RAM array, address checks, error flags and counters.
// TESTING
//  - Reset: assert rst=0 mid-run -> wb_pending=0, err_*=0, counters 0 immediately, before any clock edge.
//  - SW 0x0000_0010 <- 0xDEADBEEF, next cycle LW 0x10 -> mem_redata=0xDEADBEEF via forward, wb_pending=1, then drains.
//  - SW 0x20 <- 0x1111_1111 then SW 0x20 <- 0x2222_2222, idle, LW 0x20 -> 0x2222_2222; wr_cnt=2.
//  - SW then LW to different idx on the next cycle -> load returns RAM value, buffer commits the following idle cycle.
//  - LW 0x0000_0013 -> redata=0, err_misalign=1, rd_cnt unchanged; SW 0x0001_0000 -> RAM unchanged, err_range=1.
//  - SW 0x40 <- 0xA5A5A5A5, then rst low before any drain -> LW 0x40 returns the old RAM value (the write is discarded).

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared constants, types and address-check helper for the data-memory responder.
// Holds the enable levels, the zero word and the default RAM depth.
package data_mem_resp_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam int REG_DATA_W      = 32;
   localparam int DMEM_DEPTH_LOG2 = 10;

   typedef logic [REG_DATA_W-1:0] reg_data_t;

   localparam reg_data_t ZERO_WORD = '0;

   // Classification of the access presented this cycle; invalid accesses decode to ACC_NONE.
   typedef enum logic [1:0] {
      ACC_NONE  = 2'd0,
      ACC_LOAD  = 2'd1,
      ACC_STORE = 2'd2
   } acc_kind_e;

   typedef struct packed {
      logic misalign;
      logic range_err;
   } addr_chk_t;

   // Byte address must be word aligned and lie inside the 2^(depth_log2+2)-byte window.
   function automatic addr_chk_t check_addr(input logic [31:0] addr, input int unsigned depth_log2);
      addr_chk_t chk;
      chk.misalign  = (addr[1:0] != 2'b00);
      chk.range_err = ((addr >> (depth_log2 + 2)) != 32'd0);
      return chk;
   endfunction

endpackage

// File: rtl/data_mem_resp_wbuf.sv
// One-entry posted-write buffer: holds the newest store, commits it to RAM on the next edge,
// and offers the held word for store-to-load forwarding.
module dmem_wbuf
   import data_mem_resp_pkg::*;
#(
   parameter int IDX_W = DMEM_DEPTH_LOG2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  reg_data_t        wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             pending,
   output logic             commit_en,
   output logic [IDX_W-1:0] commit_idx,
   output reg_data_t        commit_data,
   output logic             fwd_hit,
   output reg_data_t        fwd_data
);

   logic             buf_valid;
   logic [IDX_W-1:0] buf_idx;
   reg_data_t        buf_data;

   // A held entry always retires on the next edge: either displaced by a new store or drained.
   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_valid <= 1'b0;
         buf_idx   <= '0;
         buf_data  <= ZERO_WORD;
      end else if (wr_en) begin
         buf_valid <= 1'b1;
         buf_idx   <= wr_idx;
         buf_data  <= wr_data;
      end else begin
         buf_valid <= 1'b0;
      end
   end

   assign pending     = buf_valid;
   assign commit_en   = buf_valid;
   assign commit_idx  = buf_idx;
   assign commit_data = buf_data;
   assign fwd_hit     = buf_valid && (buf_idx == rd_idx);
   assign fwd_data    = buf_data;

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: word RAM behind a posted-write buffer, zero-latency load data,
// sticky address-error flags and load/store counters.
module data_mem_resp
   import data_mem_resp_pkg::*;
#(
   parameter int DEPTH_LOG2 = DMEM_DEPTH_LOG2,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_ce,
   input  logic             mem_wrn,
   input  logic [31:0]      mem_wraddr,
   input  reg_data_t        mem_wrdata,
   output reg_data_t        mem_redata,
   output logic             wb_pending,
   output logic             err_misalign,
   output logic             err_range,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   reg_data_t             ram [DEPTH];
   logic [DEPTH_LOG2-1:0] idx;
   addr_chk_t             chk;
   acc_kind_e             acc;

   logic                  commit_en;
   logic [DEPTH_LOG2-1:0] commit_idx;
   reg_data_t             commit_data;
   logic                  fwd_hit;
   reg_data_t             fwd_data;

   assign idx = mem_wraddr[DEPTH_LOG2+1:2];

   // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      chk = check_addr(mem_wraddr, DEPTH_LOG2);
      acc = ACC_NONE;
      if (mem_ce == ENABLE && !chk.misalign && !chk.range_err) begin
         acc = (mem_wrn == ENABLE) ? ACC_STORE : ACC_LOAD;
      end
   end

   dmem_wbuf #(
      .IDX_W (DEPTH_LOG2)
   ) u_wbuf (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (acc == ACC_STORE),
      .wr_idx      (idx),
      .wr_data     (mem_wrdata),
      .rd_idx      (idx),
      .pending     (wb_pending),
      .commit_en   (commit_en),
      .commit_idx  (commit_idx),
      .commit_data (commit_data),
      .fwd_hit     (fwd_hit),
      .fwd_data    (fwd_data)
   );

   // NOTE: the RAM array has no reset; clearing it would need a per-word reset network.
   always_ff @(posedge clk) begin
      if (commit_en) begin
         ram[commit_idx] <= commit_data;
      end
   end

   // The buffer holds the newest store, so it takes priority over the RAM word.
   always_comb begin
      mem_redata = ZERO_WORD;
      if (acc != ACC_NONE) begin
         mem_redata = fwd_hit ? fwd_data : ram[idx];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_misalign <= 1'b0;
         err_range    <= 1'b0;
      end else if (mem_ce == ENABLE) begin
         if (chk.misalign)  err_misalign <= 1'b1;
         if (chk.range_err) err_range    <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_cnt <= '0;
         wr_cnt <= '0;
      end else begin
         if (acc == ACC_LOAD)  rd_cnt <= rd_cnt + CNT_W'(1);
         if (acc == ACC_STORE) wr_cnt <= wr_cnt + CNT_W'(1);
      end
   end

endmodule
